i2c_reg_arb: RTL
================

# i2c_reg_arb

Transaction controller and RAM arbiter behind the I2C slave byte engine. Turns byte-level I2C events (address match, written byte, read request, stop) into register-pointer sequencing with auto-increment. Shares one external single-port register RAM between that I2C path and a local host port; I2C has fixed priority.

## Interface
- AW, 8, register pointer / RAM address width; pointer wraps 2^AW-1 -> 0
- RST_PTR, 0, pointer value after reset
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i2c_addr_ok  in  1  one-cycle pulse: slave address matched (after START or repeated START)
- i2c_rw  in  1  R/W bit, valid with i2c_addr_ok (1 = read)
- i2c_wr_byte  in  1  one-cycle pulse: master wrote a byte
- i2c_wdata  in  8  byte, valid with i2c_wr_byte
- i2c_rd_req  in  1  one-cycle pulse: byte engine needs next byte to transmit
- i2c_stop  in  1  one-cycle pulse: STOP detected
- i2c_rdata  out  8  byte for transmission, held until next i2c_rd_valid
- i2c_rd_valid  out  1  one-cycle pulse: i2c_rdata updated
- i2c_ovr  out  1  one-cycle pulse: new I2C access arrived while previous still pending
- host_req  in  1  level; held until host_ack
- host_we  in  1  1 = write, stable while host_req
- host_addr  in  AW  stable while host_req
- host_wdata  in  8  stable while host_req
- host_ack  out  1  one-cycle pulse: host access complete
- host_rdata  out  8  read data, valid with host_ack (hold otherwise)
- ram_en, ram_we  out  1  registered RAM strobe / write enable
- ram_addr  out  AW  registered RAM address
- ram_wdata  out  8  registered RAM write data
- ram_rdata  in  8  RAM read data, valid one cycle after ram_en read
- busy  out  1  FSM not IDLE
- ptr  out  AW  current register pointer

## Operation
- Reset: FSM IDLE, ptr=RST_PTR, all pending flags clear; every output 0 except ptr.
- FSM states: IDLE, WPTR, WDATA, RDATA.
  - Any state, i2c_addr_ok & !i2c_rw -> WPTR; i2c_addr_ok & i2c_rw -> RDATA (repeated START keeps ptr).
  - WPTR, i2c_wr_byte -> ptr=i2c_wdata[AW-1:0]; -> WDATA. No RAM access.
  - WDATA, i2c_wr_byte -> latch write (ptr, data) as I2C pending; ptr+1.
  - RDATA, i2c_rd_req -> latch read at ptr as I2C pending; ptr+1.
  - i2c_stop -> IDLE from any state; ptr kept; an already latched access still completes.
  - i2c_wr_byte / i2c_rd_req in IDLE, or i2c_rd_req in WPTR/WDATA, or i2c_wr_byte in RDATA: ignored.
- Single I2C pending slot. New write/read while slot full: i2c_ovr pulse, new access dropped, ptr not incremented.
- Arbitration each edge: I2C pending wins; else host_req & !host_busy granted. host_busy set on grant, cleared on host_ack.
- Grant loads ram_en=1, ram_we, ram_addr, ram_wdata for exactly one cycle; no grant -> ram_en=0.
- Pointer arithmetic modulo 2^AW.

## Timing
- I2C read: i2c_rd_req sampled edge E0 -> ram_en high after E1 -> RAM captures E2 -> i2c_rdata/i2c_rd_valid registered at E3 (3-cycle latency) when host not competing; host never delays I2C by more than 0 cycles.
- I2C write: i2c_wr_byte at E0 -> ram_en/ram_we high after E1.
- Host: host_req seen at edge G with no I2C pending -> ram strobe after G; host_ack (and host_rdata for reads) registered at G+2, for writes too. Lost arbitration retries next edge.
- Simultaneous i2c_addr_ok and i2c_stop: addr_ok wins.
- Reset asserted mid-access: immediate return to reset values; in-flight ack/valid dropped.

## Test plan
- Write 0x10 after addr_ok(rw=0), then bytes 0xA5,0x5A -> RAM writes addr 0x10=0xA5, 0x11=0x5A; ptr=0x12; busy=1 until i2c_stop.
- Repeated START addr_ok(rw=1) after pointer 0x10, RAM preloaded, two i2c_rd_req -> i2c_rd_valid 3 cycles after each, data 0xA5 then 0x5A; ptr=0x12.
- Pointer 0xFF, write 0x11,0x22 -> RAM 0xFF=0x11, 0x00=0x22 (wrap); ptr=0x01.
- host_req read 0x11 held, i2c_wr_byte same cycle -> I2C write strobe first, host strobe next cycle, host_ack with 0x5A.
- Two i2c_rd_req on consecutive cycles while host holds grant pattern -> second gives i2c_ovr pulse, ptr increments once.
- reset_n low between i2c_rd_req and i2c_rd_valid -> no i2c_rd_valid, ptr=RST_PTR, ram_en=0.

Source files
------------

// File: rtl/i2c_reg_arb.sv
// I2C register-transaction controller and single-port RAM arbiter.
// I2C byte events drive a register pointer with auto-increment. Accepted
// I2C accesses sit in a one-entry slot and always win the RAM over the host.
module i2c_reg_arb #(
  parameter int unsigned   AW      = 8,
  parameter logic [AW-1:0] RST_PTR = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i2c_addr_ok,
  input  logic          i2c_rw,
  input  logic          i2c_wr_byte,
  input  logic [7:0]    i2c_wdata,
  input  logic          i2c_rd_req,
  input  logic          i2c_stop,
  output logic [7:0]    i2c_rdata,
  output logic          i2c_rd_valid,
  output logic          i2c_ovr,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          busy,
  output logic [AW-1:0] ptr
);

  typedef enum logic [1:0] {IDLE, WPTR, WDATA, RDATA} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          pend_q, pend_d, pend_we_q, pend_we_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_wdata_q, pend_wdata_d;
  logic          ovr_q, ovr_d;
  logic          host_busy_q, host_busy_d;
  logic          ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          ird1_q, ird1_d, ird2_q, ird2_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          hs1_q, hs1_d, hs1_we_q, hs1_we_d;
  logic          hs2_q, hs2_d, hs2_we_q, hs2_we_d;
  logic          ack_q, ack_d;
  logic [7:0]    hrdata_q, hrdata_d;
  logic          i2c_new, grant_host;

  // Transaction sequencing, arbitration and read-return pipelines
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pend_d       = 1'b0;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    ovr_d        = 1'b0;
    i2c_new      = 1'b0;

    // A full slot is always granted this edge, so it frees after one cycle.
    case (state_q)
      WPTR: if (i2c_wr_byte) begin
        ptr_d   = i2c_wdata[AW-1:0];
        state_d = WDATA;
      end
      WDATA: if (i2c_wr_byte) begin
        if (pend_q) ovr_d = 1'b1;
        else begin
          i2c_new      = 1'b1;
          pend_we_d    = 1'b1;
          pend_addr_d  = ptr_q;
          pend_wdata_d = i2c_wdata;
          ptr_d        = ptr_q + 1'b1;
        end
      end
      RDATA: if (i2c_rd_req) begin
        if (pend_q) ovr_d = 1'b1;
        else begin
          i2c_new     = 1'b1;
          pend_we_d   = 1'b0;
          pend_addr_d = ptr_q;
          ptr_d       = ptr_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (i2c_new) pend_d = 1'b1;

    if (i2c_stop)    state_d = IDLE;
    if (i2c_addr_ok) state_d = i2c_rw ? RDATA : WPTR;

    // An I2C access being latched this edge also blocks the host, so the
    // I2C strobe always comes first.
    grant_host  = host_req & ~host_busy_q & ~pend_q & ~i2c_new;
    ram_en_d    = pend_q | grant_host;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (pend_q) begin
      ram_we_d    = pend_we_q;
      ram_addr_d  = pend_addr_q;
      ram_wdata_d = pend_wdata_q;
    end else if (grant_host) begin
      ram_we_d    = host_we;
      ram_addr_d  = host_addr;
      ram_wdata_d = host_wdata;
    end

    ird1_d     = pend_q & ~pend_we_q;
    ird2_d     = ird1_q;
    rd_valid_d = ird2_q;
    rdata_d    = ird2_q ? ram_rdata : rdata_q;

    hs1_d    = grant_host;
    hs1_we_d = host_we;
    hs2_d    = hs1_q;
    hs2_we_d = hs1_we_q;
    ack_d    = hs2_q;
    hrdata_d = (hs2_q & ~hs2_we_q) ? ram_rdata : hrdata_q;

    host_busy_d = host_busy_q;
    if (grant_host)  host_busy_d = 1'b1;
    else if (hs2_q)  host_busy_d = 1'b0;
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= RST_PTR;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      ovr_q        <= 1'b0;
      host_busy_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ird1_q       <= 1'b0;
      ird2_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rdata_q      <= '0;
      hs1_q        <= 1'b0;
      hs1_we_q     <= 1'b0;
      hs2_q        <= 1'b0;
      hs2_we_q     <= 1'b0;
      ack_q        <= 1'b0;
      hrdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      ovr_q        <= ovr_d;
      host_busy_q  <= host_busy_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ird1_q       <= ird1_d;
      ird2_q       <= ird2_d;
      rd_valid_q   <= rd_valid_d;
      rdata_q      <= rdata_d;
      hs1_q        <= hs1_d;
      hs1_we_q     <= hs1_we_d;
      hs2_q        <= hs2_d;
      hs2_we_q     <= hs2_we_d;
      ack_q        <= ack_d;
      hrdata_q     <= hrdata_d;
    end
  end

  assign i2c_rdata    = rdata_q;
  assign i2c_rd_valid = rd_valid_q;
  assign i2c_ovr      = ovr_q;
  assign host_ack     = ack_q;
  assign host_rdata   = hrdata_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign busy         = (state_q != IDLE);
  assign ptr          = ptr_q;

endmodule
